// File: rtl/reg_de_pkg.sv
// Shared pipeline-register constants: bubble encodings and hazard timing helpers.
package reg_de_pkg;
  localparam int          TNEW_W   = 2;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [4:0]  EXC_NONE = 5'd0;

  // Tnew counts down one stage per register; it saturates at 0 rather than wrapping to 3.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction
endpackage

// File: rtl/reg_de_if.sv
// D-to-E pipeline boundary: hazard controls, D-stage operands and registered E-stage view.
interface reg_de_if;
  import reg_de_pkg::*;

  logic              stall, flush;
  logic [31:0]       PC_D, Instr_D, RD1_D, RD2_D, Ext_D;
  logic [4:0]        A3_D, ExcCode_D;
  logic [TNEW_W-1:0] Tnew_D;
  logic              BD_D;

  logic [31:0]       PC_E, Instr_E, RD1_E, RD2_E, Ext_E;
  logic [4:0]        A3_E, ExcCode_E;
  logic [TNEW_W-1:0] Tnew_E;
  logic              BD_E, Valid_E;
  logic [31:0]       BubbleCnt;

  modport master (
    output stall, flush, PC_D, Instr_D, RD1_D, RD2_D, Ext_D, A3_D, ExcCode_D, Tnew_D, BD_D,
    input  PC_E, Instr_E, RD1_E, RD2_E, Ext_E, A3_E, ExcCode_E, Tnew_E, BD_E, Valid_E, BubbleCnt
  );

  modport slave (
    input  stall, flush, PC_D, Instr_D, RD1_D, RD2_D, Ext_D, A3_D, ExcCode_D, Tnew_D, BD_D,
    output PC_E, Instr_E, RD1_E, RD2_E, Ext_E, A3_E, ExcCode_E, Tnew_E, BD_E, Valid_E, BubbleCnt
  );
endinterface

// File: rtl/reg_de_pipe_field.sv
// One pipeline-register field: sync reset > clear > bubble > load.
module pipe_field #(
  parameter int           W    = 32,
  parameter bit           KEEP = 1'b0,
  parameter logic [W-1:0] CLR  = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // KEEP fields still track D during a bubble so EPC stays correct for an interrupted bubble.
  always_ff @(posedge clk) begin
    if (reset)       q <= '0;
    else if (clr)    q <= CLR;
    else if (bubble) q <= KEEP ? d : CLR;
    else             q <= d;
  end
endmodule

// File: rtl/reg_de.sv
// Decode-to-Execute pipeline register with bubble insertion, flush and bubble counter.
module reg_de
  import reg_de_pkg::*;
(
  input logic     clk,
  input logic     reset,
  reg_de_if.slave de
);
  logic [1:0]  vld_pipe;
  logic [31:0] bubble_cnt;

  assign vld_pipe[0] = 1'b1;

  pipe_field #(.W(32), .KEEP(1'b1)) u_pc (.clk(clk), .reset(reset), .clr(de.flush), .bubble(de.stall),
    .d(de.PC_D), .q(de.PC_E));
  pipe_field #(.W(32), .CLR(NOP)) u_instr (.clk(clk), .reset(reset), .clr(de.flush), .bubble(de.stall),
    .d(de.Instr_D), .q(de.Instr_E));
  pipe_field #(.W(32)) u_rd1 (.clk(clk), .reset(reset), .clr(de.flush), .bubble(de.stall),
    .d(de.RD1_D), .q(de.RD1_E));
  pipe_field #(.W(32)) u_rd2 (.clk(clk), .reset(reset), .clr(de.flush), .bubble(de.stall),
    .d(de.RD2_D), .q(de.RD2_E));
  pipe_field #(.W(32)) u_ext (.clk(clk), .reset(reset), .clr(de.flush), .bubble(de.stall),
    .d(de.Ext_D), .q(de.Ext_E));
  pipe_field #(.W(5)) u_a3 (.clk(clk), .reset(reset), .clr(de.flush), .bubble(de.stall),
    .d(de.A3_D), .q(de.A3_E));
  pipe_field #(.W(TNEW_W)) u_tnew (.clk(clk), .reset(reset), .clr(de.flush), .bubble(de.stall),
    .d(tnew_dec(de.Tnew_D)), .q(de.Tnew_E));
  pipe_field #(.W(1), .KEEP(1'b1)) u_bd (.clk(clk), .reset(reset), .clr(de.flush), .bubble(de.stall),
    .d(de.BD_D), .q(de.BD_E));
  pipe_field #(.W(5), .CLR(EXC_NONE)) u_exc (.clk(clk), .reset(reset), .clr(de.flush), .bubble(de.stall),
    .d(de.ExcCode_D), .q(de.ExcCode_E));
  pipe_field #(.W(1)) u_vld (.clk(clk), .reset(reset), .clr(de.flush), .bubble(de.stall),
    .d(vld_pipe[0]), .q(vld_pipe[1]));

  assign de.Valid_E = vld_pipe[1];

  // Flush outranks stall, so a flushed stall cycle is not counted as a bubble.
  always_ff @(posedge clk) begin
    if (reset)                       bubble_cnt <= '0;
    else if (de.stall && !de.flush)  bubble_cnt <= bubble_cnt + 32'd1;
  end

  assign de.BubbleCnt = bubble_cnt;
endmodule

// File: tb/tb_reg_de.sv
// Scoreboard bench for reg_de: directed hazard cases plus randomized traffic vs. a reference model.
module tb_reg_de;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_de_if de_if ();
  reg_de dut (.clk(clk), .reset(reset), .de(de_if));

  typedef struct packed {
    logic [31:0] pc, instr, rd1, rd2, ext;
    logic [4:0]  a3;
    logic [1:0]  tnew;
    logic        bd;
    logic [4:0]  exc;
    logic        valid;
    logic [31:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] model_cnt = '0;

  // Reference: what the E stage must show after an edge with these D-side inputs.
  task automatic apply(input logic r, input logic st, input logic fl,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] ext,
                       input logic [4:0] a3, input logic [1:0] tnew, input logic bd,
                       input logic [4:0] exc, input bit frc);
    obs_t e;
    @(negedge clk);
    if (frc) begin
      force dut.bubble_cnt = 32'hFFFF_FFFF;
      #1 release dut.bubble_cnt;
      model_cnt = 32'hFFFF_FFFF;
    end
    reset = r; de_if.stall = st; de_if.flush = fl;
    de_if.PC_D = pc; de_if.Instr_D = instr; de_if.RD1_D = rd1; de_if.RD2_D = rd2;
    de_if.Ext_D = ext; de_if.A3_D = a3; de_if.Tnew_D = tnew; de_if.BD_D = bd; de_if.ExcCode_D = exc;
    e = '0;
    if (r) begin
      model_cnt = 0;
    end else if (fl) begin
      // everything zero, counter kept
    end else if (st) begin
      e.pc = pc; e.bd = bd;
      model_cnt = model_cnt + 1;
    end else begin
      e.pc = pc; e.instr = instr; e.rd1 = rd1; e.rd2 = rd2; e.ext = ext;
      e.a3 = a3; e.bd = bd; e.exc = exc; e.valid = 1'b1;
      e.tnew = (tnew == 0) ? 2'd0 : tnew - 2'd1;
    end
    e.cnt = model_cnt;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] instr, input logic [1:0] tnew);
    apply(1'b0, 1'b0, 1'b0, pc, instr, $urandom, $urandom, $urandom, 5'($urandom), tnew, 1'b0, 5'd0, 1'b0);
  endtask

  // Monitor: the E stage presents a result every cycle.
  always @(posedge clk) begin
    obs_t a, e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{de_if.PC_E, de_if.Instr_E, de_if.RD1_E, de_if.RD2_E, de_if.Ext_E, de_if.A3_E,
            de_if.Tnew_E, de_if.BD_E, de_if.ExcCode_E, de_if.Valid_E, de_if.BubbleCnt};
      n_vec++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL e_stage vec %0d: got %h expected %h", n_vec, a, e);
      end
    end
  end

  initial begin
    reset = 1'b1; de_if.stall = 1'b0; de_if.flush = 1'b0;
    de_if.PC_D = '0; de_if.Instr_D = '0; de_if.RD1_D = '0; de_if.RD2_D = '0; de_if.Ext_D = '0;
    de_if.A3_D = '0; de_if.Tnew_D = '0; de_if.BD_D = 1'b0; de_if.ExcCode_D = '0;

    repeat (2) apply(1'b1, 1'b1, 1'b1, '1, '1, '1, '1, '1, '1, '1, 1'b1, '1, 1'b0);

    apply(1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h3C01_1234, 32'h0, 32'h0, 32'h1234_0000,
          5'd1, 2'd2, 1'b0, 5'd0, 1'b0);
    load(32'h0000_3004, 32'h0000_0021, 2'd0);
    load(32'h0000_3008, 32'h8C22_0000, 2'd3);

    repeat (3) apply(1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'h1234_5678, 32'hAAAA_AAAA, 32'h5555_5555,
                     32'hFFFF_8000, 5'd31, 2'd2, 1'b1, 5'd4, 1'b0);
    load(32'h0000_300C, 32'h0000_0000, 2'd1);

    apply(1'b0, 1'b1, 1'b1, 32'h0000_3010, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3, 5'd7, 2'd3, 1'b1, 5'd12, 1'b0);
    load(32'h0000_3014, 32'h2402_0005, 2'd2);

    apply(1'b0, 1'b1, 1'b0, 32'h0000_3018, 32'h1, 32'h2, 32'h3, 32'h4, 5'd5, 2'd1, 1'b0, 5'd0, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 32'h0000_301C, 32'h1, 32'h2, 32'h3, 32'h4, 5'd5, 2'd1, 1'b1, 5'd0, 1'b0);

    apply(1'b1, 1'b1, 1'b0, '1, '1, '1, '1, '1, '1, '1, 1'b1, '1, 1'b0);
    load(32'h0000_3020, 32'h0000_000C, 2'd2);

    for (int i = 0; i < 400; i++) begin
      logic r, st, fl;
      r  = ($urandom_range(99) < 3);
      st = ($urandom_range(99) < 30);
      fl = ($urandom_range(99) < 12);
      apply(r, st, fl, $urandom, $urandom, $urandom, $urandom, $urandom,
            5'($urandom), 2'($urandom), 1'($urandom), 5'($urandom), 1'b0);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
